// File: rtl/core_irq_aggr.sv
// core_irq_aggr: synchronises raw interrupt sources, latches edge channels or
// tracks level channels, masks with the per-channel enable and folds the
// result onto the core's fast interrupt lines. It also reports the lowest
// enabled pending channel id.
module core_irq_aggr #(
  parameter int NumIrqs    = 16,
  parameter int NumOut     = 16,
  parameter int SyncStages = 2,
  localparam int IdW       = (NumIrqs > 1) ? $clog2(NumIrqs) : 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NumIrqs-1:0] irqs_i,
  input  logic [NumIrqs-1:0] edge_mode_i,
  input  logic [NumIrqs-1:0] enable_i,
  input  logic               clr_valid_i,
  input  logic [IdW-1:0]     clr_id_i,
  output logic [NumIrqs-1:0] pending_o,
  output logic               irq_valid_o,
  output logic [IdW-1:0]     irq_id_o,
  output logic [NumOut-1:0]  irq_fast_o
);

  logic [NumIrqs-1:0] s;
  logic [NumIrqs-1:0] prev_q;
  logic [NumIrqs-1:0] pending_q;
  logic [NumIrqs-1:0] pending_d;
  logic [NumIrqs-1:0] rise;
  logic [NumIrqs-1:0] clr_hit;
  logic [NumIrqs-1:0] masked;
  logic [IdW-1:0]     id_d;
  logic [NumOut-1:0]  fast_d;
  logic               valid_q;
  logic [IdW-1:0]     id_q;
  logic [NumOut-1:0]  fast_q;

  if (SyncStages == 0) begin : g_nosync
    assign s = irqs_i;
  end else begin : g_sync
    logic [NumIrqs-1:0] sync_q [SyncStages];

    // Shift raw sources through the synchroniser chain.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        for (int k = 0; k < SyncStages; k++) sync_q[k] <= '0;
      end else begin
        sync_q[0] <= irqs_i;
        for (int k = 1; k < SyncStages; k++) sync_q[k] <= sync_q[k-1];
      end
    end

    assign s = sync_q[SyncStages-1];
  end

  // Rising-edge detect and clear decode; ids past the top channel shift out
  // of the vector and so hit nothing.
  always_comb begin
    rise    = s & ~prev_q;
    clr_hit = clr_valid_i ? (NumIrqs'(1) << clr_id_i) : '0;
    // Edge channels hold until cleared, a new edge beats a same-cycle clear;
    // level channels simply follow the synchronised source.
    pending_d = (edge_mode_i & (rise | (pending_q & ~clr_hit))) |
                (~edge_mode_i & s);
  end

  // Edge-detect history and pending state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_q    <= '0;
      pending_q <= '0;
    end else begin
      prev_q    <= s;
      pending_q <= pending_d;
    end
  end

  // Mask, pick the lowest enabled pending channel and fold onto output lines.
  always_comb begin
    masked = pending_q & enable_i;
    id_d   = '0;
    for (int i = NumIrqs - 1; i >= 0; i--) begin
      if (masked[i]) id_d = IdW'(i);
    end
    fast_d = '0;
    for (int i = 0; i < NumIrqs; i++) begin
      fast_d[i % NumOut] = fast_d[i % NumOut] | masked[i];
    end
  end

  // Register the core-facing outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      id_q    <= '0;
      fast_q  <= '0;
    end else begin
      valid_q <= |masked;
      id_q    <= id_d;
      fast_q  <= fast_d;
    end
  end

  assign pending_o   = pending_q;
  assign irq_valid_o = valid_q;
  assign irq_id_o    = id_q;
  assign irq_fast_o  = fast_q;

endmodule
